// File: rtl/btn_event_arb.sv
// Debounced push-button front end: sync + debounce + press one-shot, round-robin onto one event port.
// Press-to-valid latency DB_CYCLES+4 edges; evt_idx_o holds while valid && !ready, repeat presses coalesce (drop_o).
module btn_event_arb #(
    parameter  int N_BTN     = 4,
    parameter  int DB_CYCLES = 4,
    localparam int IDX_W     = $clog2(N_BTN)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_BTN-1:0] btn_i,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [IDX_W-1:0] evt_idx_o,
    output logic [N_BTN-1:0] held_o,
    output logic             drop_o
);

    localparam int               CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [IDX_W:0]   N_EXT    = (IDX_W+1)'(N_BTN);

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [CNT_W-1:0] db_cnt [N_BTN];
    logic [N_BTN-1:0] held_d;
    logic [N_BTN-1:0] pending;
    logic [IDX_W-1:0] last_grant;

    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] clr_mask;
    logic [N_BTN-1:0] pending_nxt;
    logic             drop_nxt;
    logic             out_free;
    logic             grant_vld;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W:0]   rr_sum;
    logic [IDX_W-1:0] rr_cand;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_i;
            sync2 <= sync1;
        end
    end

    // The level only flips after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            held_o <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (sync2[i] == held_o[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    db_cnt[i] <= '0;
                    held_o[i] <= ~held_o[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise     = held_o & ~held_d;
    assign out_free = !evt_valid_o || evt_ready_i;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = last_grant;
        rr_sum    = '0;
        rr_cand   = '0;
        for (int k = 1; k <= N_BTN; k++) begin
            rr_sum = {1'b0, last_grant} + (IDX_W+1)'(k);
            if (rr_sum >= N_EXT) begin
                rr_sum = rr_sum - N_EXT;
            end
            rr_cand = rr_sum[IDX_W-1:0];
            if (!grant_vld && pending[rr_cand]) begin
                grant_vld = 1'b1;
                grant_idx = rr_cand;
            end
        end
    end

    // A press landing on the granted channel re-arms it; otherwise a set bit absorbs it.
    always_comb begin
        clr_mask = '0;
        if (out_free && grant_vld) begin
            clr_mask[grant_idx] = 1'b1;
        end
        pending_nxt = (pending & ~clr_mask) | rise;
        drop_nxt    = |(rise & pending & ~clr_mask);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            held_d  <= '0;
            pending <= '0;
            drop_o  <= 1'b0;
        end else begin
            held_d  <= held_o;
            pending <= pending_nxt;
            drop_o  <= drop_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            evt_valid_o <= 1'b0;
            evt_idx_o   <= '0;
            last_grant  <= IDX_W'(N_BTN - 1);
        end else if (out_free) begin
            if (grant_vld) begin
                evt_valid_o <= 1'b1;
                evt_idx_o   <= grant_idx;
                last_grant  <= grant_idx;
            end else begin
                evt_valid_o <= 1'b0;
            end
        end
    end

endmodule
